// File: rtl/regfile_write_scheduler.sv
// Round-robin scheduler for the single register-file write port shared by the
// ALU writeback (A) and the load unit (B), with a per-register pending-write scoreboard.
module regfile_write_scheduler #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_rd,
    output logic              claim_ready,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_stall,
    output logic [NREG-1:0]   busy
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t            last_grant;
    grant_t            last_grant_next;
    logic [1:0]        count [NREG];
    logic              xfer;
    logic [ADDR_W-1:0] xfer_rd;
    logic [DATA_W-1:0] xfer_data;
    logic              vld_p1;
    logic [ADDR_W-1:0] waddr_p1;
    logic [DATA_W-1:0] wdata_p1;

    // Pending count saturates at both ends; simultaneous claim and write cancel out.
    function automatic logic [1:0] sat_count(input logic [1:0] cur, input logic inc,
                                             input logic dec);
        if (inc && !dec) return (cur == 2'd3) ? cur : cur + 2'd1;
        if (dec && !inc) return (cur == 2'd0) ? cur : cur - 2'd1;
        return cur;
    endfunction

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) last_grant <= GRANT_B;
        else        last_grant <= last_grant_next;
    end

    always_comb begin
        a_ready         = 1'b0;
        b_ready         = 1'b0;
        last_grant_next = last_grant;
        a_ready = a_valid && (!b_valid || last_grant == GRANT_B);
        b_ready = b_valid && !a_ready;
        if (a_ready)      last_grant_next = GRANT_A;
        else if (b_ready) last_grant_next = GRANT_B;
    end

    assign xfer      = a_ready || b_ready;
    assign xfer_rd   = a_ready ? a_rd : b_rd;
    assign xfer_data = a_ready ? a_data : b_data;

    // Stage p1: granted write held for one cycle before the register file commits it.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= xfer;
            if (xfer) begin
                waddr_p1 <= xfer_rd;
                wdata_p1 <= xfer_data;
            end
        end
    end

    assign rf_we    = vld_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;

    assign claim_ready = (count[claim_rd] != 2'd3);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) count[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                count[i] <= sat_count(count[i],
                                      claim_valid && claim_ready && (claim_rd == ADDR_W'(i)),
                                      xfer && (xfer_rd == ADDR_W'(i)));
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NREG; i++) busy[i] = (count[i] != 2'd0);
    end

    // A write sitting in p1 has not reached the register file yet, so it still blocks reads.
    assign rd_stall = (count[rd_addr] != 2'd0) || (vld_p1 && (waddr_p1 == rd_addr));

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed, table-driven bench for regfile_write_scheduler: each row is one cycle of
// inputs plus the outputs expected in that cycle before the next rising edge.
module tb_regfile_write_scheduler;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       claim_valid = 1'b0;
    logic [2:0] claim_rd = '0;
    logic       claim_ready;
    logic       a_valid = 1'b0;
    logic [2:0] a_rd = '0;
    logic [7:0] a_data = '0;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [2:0] b_rd = '0;
    logic [7:0] b_data = '0;
    logic       b_ready;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [2:0] rd_addr = '0;
    logic       rd_stall;
    logic [7:0] busy;

    int errors = 0;
    int checks = 0;

    regfile_write_scheduler #(.DATA_W(8), .ADDR_W(3), .NREG(8)) dut (
        .clk(clk), .Reset(Reset),
        .claim_valid(claim_valid), .claim_rd(claim_rd), .claim_ready(claim_ready),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr(rd_addr), .rd_stall(rd_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pre_rst;
        logic       cv;
        logic [2:0] crd;
        logic       av;
        logic [2:0] ard;
        logic [7:0] ad;
        logic       bv;
        logic [2:0] brd;
        logic [7:0] bd;
        logic [2:0] ra;
        logic       e_ar;
        logic       e_br;
        logic       e_cr;
        logic       e_st;
        logic [7:0] e_busy;
        logic       e_we;
        logic [2:0] e_wa;
        logic [7:0] e_wd;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic clear_inputs();
        claim_valid = 1'b0; claim_rd = '0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        rd_addr = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
    endtask

    initial begin
        //           rst cv crd av ard ad     bv brd bd     ra  ar br cr st busy   we wa wd
        tbl[0]  = '{1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 0, 8'h00, 0, 0, 8'h00};
        tbl[1]  = '{0, 1, 3, 0, 0, 8'h00, 0, 0, 8'h00, 3,  0, 0, 1, 0, 8'h00, 0, 0, 8'h00};
        tbl[2]  = '{0, 0, 0, 1, 3, 8'h5A, 0, 0, 8'h00, 3,  1, 0, 1, 1, 8'h08, 0, 0, 8'h00};
        tbl[3]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 3,  0, 0, 1, 1, 8'h00, 1, 3, 8'h5A};
        tbl[4]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 3,  0, 0, 1, 0, 8'h00, 0, 0, 8'h00};
        // contention after reset: A first, then B
        tbl[5]  = '{1, 0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 0,  1, 0, 1, 0, 8'h00, 0, 0, 8'h00};
        tbl[6]  = '{0, 0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 0,  0, 1, 1, 0, 8'h00, 1, 1, 8'h11};
        tbl[7]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2,  0, 0, 1, 1, 8'h00, 1, 2, 8'h22};
        tbl[8]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2,  0, 0, 1, 0, 8'h00, 0, 0, 8'h00};
        // saturating claims on r5
        tbl[9]  = '{0, 1, 5, 0, 0, 8'h00, 0, 0, 8'h00, 5,  0, 0, 1, 0, 8'h00, 0, 0, 8'h00};
        tbl[10] = '{0, 1, 5, 0, 0, 8'h00, 0, 0, 8'h00, 5,  0, 0, 1, 1, 8'h20, 0, 0, 8'h00};
        tbl[11] = '{0, 1, 5, 0, 0, 8'h00, 0, 0, 8'h00, 5,  0, 0, 1, 1, 8'h20, 0, 0, 8'h00};
        tbl[12] = '{0, 1, 5, 0, 0, 8'h00, 0, 0, 8'h00, 5,  0, 0, 0, 1, 8'h20, 0, 0, 8'h00};
        tbl[13] = '{0, 0, 5, 0, 0, 8'h00, 1, 5, 8'h77, 5,  0, 1, 0, 1, 8'h20, 0, 0, 8'h00};
        tbl[14] = '{0, 0, 5, 0, 0, 8'h00, 0, 0, 8'h00, 5,  0, 0, 1, 1, 8'h20, 1, 5, 8'h77};
        // claim and write to r4 in the same cycle
        tbl[15] = '{0, 1, 4, 0, 0, 8'h00, 0, 0, 8'h00, 4,  0, 0, 1, 0, 8'h20, 0, 0, 8'h00};
        tbl[16] = '{0, 1, 4, 1, 4, 8'h44, 0, 0, 8'h00, 4,  1, 0, 1, 1, 8'h30, 0, 0, 8'h00};
        tbl[17] = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 4,  0, 0, 1, 1, 8'h30, 1, 4, 8'h44};
        tbl[18] = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 4,  0, 0, 1, 1, 8'h30, 0, 0, 8'h00};

        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].pre_rst) begin
                do_reset();
                #1;
                chk($sformatf("v%0d.rst_we", i), rf_we, 0);
                chk($sformatf("v%0d.rst_waddr", i), rf_waddr, 0);
                chk($sformatf("v%0d.rst_wdata", i), rf_wdata, 0);
            end else begin
                @(negedge clk);
            end
            claim_valid = tbl[i].cv; claim_rd = tbl[i].crd;
            a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bd;
            rd_addr = tbl[i].ra;
            #1;
            chk($sformatf("v%0d.a_ready", i), a_ready, tbl[i].e_ar);
            chk($sformatf("v%0d.b_ready", i), b_ready, tbl[i].e_br);
            chk($sformatf("v%0d.claim_ready", i), claim_ready, tbl[i].e_cr);
            chk($sformatf("v%0d.rd_stall", i), rd_stall, tbl[i].e_st);
            chk($sformatf("v%0d.busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d.rf_we", i), rf_we, tbl[i].e_we);
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d.rf_waddr", i), rf_waddr, tbl[i].e_wa);
                chk($sformatf("v%0d.rf_wdata", i), rf_wdata, tbl[i].e_wd);
            end
        end

        // Asynchronous reset while a write is registered and r6 has two claims pending.
        do_reset();
        claim_valid = 1'b1; claim_rd = 3'd6;
        @(negedge clk);
        @(negedge clk);
        claim_valid = 1'b0;
        a_valid = 1'b1; a_rd = 3'd1; a_data = 8'h33;
        #1;
        chk("ar.a_ready", a_ready, 1);
        chk("ar.busy_pre", busy, 8'h40);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        chk("ar.rf_we_pre", rf_we, 1);
        chk("ar.rf_wdata_pre", rf_wdata, 8'h33);
        Reset = 1'b0;
        #1;
        chk("ar.rf_we_async", rf_we, 0);
        chk("ar.busy_async", busy, 8'h00);
        chk("ar.rf_waddr_async", rf_waddr, 0);
        chk("ar.rf_wdata_async", rf_wdata, 0);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("ar.rf_we_release", rf_we, 0);
        @(negedge clk);
        #1;
        chk("ar.rf_we_after", rf_we, 0);
        chk("ar.busy_after", busy, 8'h00);
        chk("ar.claim_ready_after", claim_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
